muxn_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one N-way, WIDTH-bit mux datapath (the `commonlib_muxn` tree) between N valid/ready requesters. It picks one requester per cycle, drives the mux select and captures the selected word into a single registered output stage with its own valid/ready handshake. It sits between per-lane producers and a single downstream consumer, for example a shared memory port or a bus master.

---
 rtl/muxn_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_muxn_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_rr_arbiter.sv
// rtl/muxn_rr_arbiter.sv - round-robin arbiter driving a shared N-way mux into one registered output stage
// Optional burst locking compiled in with `define MUXN_ARB_LOCK_EN.
module muxn_rr_arbiter #(
  parameter int N     = 5,
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         req_valid,
  input  logic [WIDTH-1:0]     req_data [N-1:0],
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] rr_win;
  logic [SEL_W-1:0] cand;
  logic             rr_found;
  logic [SEL_W-1:0] win;
  logic             grant;
  logic             grant_en;
  logic             ptr_adv;
  logic             load;
  logic [WIDTH-1:0] mux_data;

  assign load = !out_valid || out_ready;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k >= N) ? SEL_W'(int'(ptr_q) + k - N)
                                    : SEL_W'(int'(ptr_q) + k);
      if (req_valid[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

`ifdef MUXN_ARB_LOCK_EN
  typedef enum logic {ARB, LOCK} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q    <= ARB;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (grant_en) begin
      if (req_last[win]) begin
        state_d = ARB;
      end else begin
        state_d    = LOCK;
        lock_idx_d = win;
      end
    end
  end

  // While locked only the owning requester can be granted.
  always_comb begin
    if (state_q == LOCK) begin
      win   = lock_idx_q;
      grant = req_valid[lock_idx_q];
    end else begin
      win   = rr_win;
      grant = rr_found;
    end
  end

  assign ptr_adv = grant_en && (state_d == ARB);
`else
  wire unused_req_last = ^req_last;

  assign win     = rr_win;
  assign grant   = rr_found;
  assign ptr_adv = grant_en;
`endif

  assign grant_en  = load && grant && ASYNCRESETN;
  assign req_ready = grant_en ? (N'(1) << win) : '0;
  assign mux_data  = req_data[win];
  assign ptr_nxt   = (int'(win) == N - 1) ? '0 : win + SEL_W'(1);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_q     <= '0;
    end else if (load) begin
      out_valid <= grant;
      if (grant) begin
        out_data <= mux_data;
        out_sel  <= win;
      end
      if (ptr_adv) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_muxn_rr_arbiter.sv
// tb/tb_muxn_rr_arbiter.sv - scoreboard bench for muxn_rr_arbiter (N=5 and N=1 instances)
module tb_muxn_rr_arbiter;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [W-1:0]  req_data [N-1:0];
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;

  logic          v1, l1, r1, ov1, ordy1;
  logic [W-1:0]  d1 [0:0];
  logic [W-1:0]  od1;
  logic          os1;

  muxn_rr_arbiter #(.N(N), .WIDTH(W), .SEL_W(SW)) dut (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  muxn_rr_arbiter #(.N(1), .WIDTH(W), .SEL_W(1)) dut1 (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .req_valid(v1), .req_data(d1), .req_last(l1),
    .req_ready(r1), .out_valid(ov1), .out_data(od1),
    .out_sel(os1), .out_ready(ordy1)
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [W-1:0] data);
    exp_t e;
    e.sel  = SW'(sel);
    e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual_sel=%0d actual_data=%0h required=none", out_sel, out_data);
      end else begin
        check("sb_sel", 64'(out_sel), 64'(q[0].sel));
        check("sb_data", 64'(out_data), 64'(q[0].data));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [W-1:0] dbeats [3];
  logic [N-1:0] g;
  int           beat2;
  bit           done0;
  logic [2:0]   pat;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_last = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    v1 = 1'b0; l1 = 1'b1; d1[0] = '0; ordy1 = 1'b1;
    repeat (2) tick();
    req_valid = '1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_sel", 64'(out_sel), 64'd0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Fairness with all requesters valid.
    for (int i = 0; i < N; i++) req_data[i] = 32'hA0 + i;
    for (int i = 0; i < N; i++) push(i, 32'hA0 + i);
    push(0, 32'hA0);
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_nobubble", 64'(out_valid), 64'd1);
    end
    req_valid = '0;
    tick();
    check("fair_drain", 64'(out_valid), 64'd0);

    // Pointer skip: move ptr to 2 via requester 1, then 1 and 3 valid.
    for (int i = 0; i < N; i++) req_data[i] = 32'hB0 + i;
    push(1, 32'hB1);
    req_valid = 5'b00010;
    tick();
    push(3, 32'hB3); push(1, 32'hB1); push(3, 32'hB3);
    req_valid = 5'b01010;
    repeat (3) tick();
    req_valid = '0;
    tick();
    check("skip_drain", 64'(out_valid), 64'd0);

    // Back-pressure.
    req_data[0] = 32'hC0; out_ready = 1'b0; req_valid = 5'b00001;
    push(0, 32'hC0); push(0, 32'hC1);
    tick();
    req_data[0] = 32'hC1;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hC0);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 64'(req_ready), 64'b00001);
    tick();
    req_valid = '0;
    check("bp_same_edge", 64'(out_data), 64'hC1);
    tick();
    check("bp_drain", 64'(out_valid), 64'd0);

    // Burst from requester 2 (last=0,0,1) while requester 0 waits; ptr is 1 here.
    dbeats[0] = 32'hD0; dbeats[1] = 32'hD1; dbeats[2] = 32'hD2;
`ifdef MUXN_ARB_LOCK_EN
    push(2, 32'hD0); push(2, 32'hD1); push(2, 32'hD2); push(0, 32'hE0);
`else
    push(2, 32'hD0); push(0, 32'hE0); push(2, 32'hD1); push(2, 32'hD2);
`endif
    beat2 = 0; done0 = 1'b0;
    req_data[0] = 32'hE0; req_last[0] = 1'b1;
    req_data[2] = dbeats[0]; req_last[2] = 1'b0;
    req_valid = 5'b00101;
    for (int c = 0; c < 10 && (beat2 < 3 || !done0); c++) begin
      @(negedge clk);
      g = req_ready;
      tick();
      if (g[2]) beat2++;
      if (g[0]) done0 = 1'b1;
      req_valid[0] = !done0;
      req_valid[2] = (beat2 < 3);
      if (beat2 < 3) begin
        req_data[2] = dbeats[beat2];
        req_last[2] = (beat2 == 2);
      end
    end
    check("burst_done", 64'({beat2[1:0], done0}), 64'({2'd3, 1'b1}));
    req_valid = '0; req_last = '1;
    tick();
    check("burst_drain", 64'(out_valid), 64'd0);

    // Reset with a word pending (and, when locking, mid-burst).
    out_ready = 1'b0; req_data[3] = 32'hF3; req_last[3] = 1'b0; req_valid = 5'b01000;
    tick();
    check("prerst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_sel", 64'(out_sel), 64'd0);
    req_valid = '0; req_last = '1;
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = 32'h60 + i;
    push(0, 32'h60);
    req_valid = '1;
    tick();
    req_valid = '0;
    tick();
    check("postrst_drain", 64'(out_valid), 64'd0);

    // N=1 instance: valid 1,0,1.
    pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      v1 = pat[k];
      d1[0] = 32'h100 + k;
      #1;
      check("n1_ready", 64'(r1), 64'(pat[k]));
      tick();
      check("n1_valid", 64'(ov1), 64'(pat[k]));
      check("n1_sel", 64'(os1), 64'd0);
      if (pat[k]) check("n1_data", 64'(od1), 64'(32'h100 + k));
    end
    v1 = 1'b0;

    repeat (3) tick();
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
